// File: rtl/tpu_pkg.sv
// Shared types and sizing for the systolic-array result path.
// Tile geometry defaults and the deskew collector state encoding.
package tpu_pkg;

  localparam int ARRAY_SIZE = 8;
  localparam int W          = 16;
  localparam int ADDR_WIDTH = 6;
  localparam int NUM_DIAG   = 2 * ARRAY_SIZE - 1;
  localparam int ROW_IDX_W  = $clog2(ARRAY_SIZE);

  typedef enum logic {
    COLLECT = 1'b0,
    DRAIN   = 1'b1
  } deskew_state_t;

endpackage

// File: rtl/deskew_lane_mux.sv
// Maps diagonal index d on lane LANE to column d-LANE; col_vld when the lane carries a tile element.
// Purely combinational, no latency, no flow control.
module deskew_lane_mux #(
  parameter int LANE       = 0,
  parameter int ADDR_WIDTH = 6,
  parameter int ARRAY_SIZE = 8,
  parameter int COL_W      = 3
) (
  input  logic [ADDR_WIDTH-1:0] diag,
  output logic [COL_W-1:0]      col,
  output logic                  col_vld
);

  logic [ADDR_WIDTH:0] diff;

  // One extra bit so d < LANE wraps to a large value instead of aliasing a column.
  assign diff    = {1'b0, diag} - (ADDR_WIDTH + 1)'(LANE);
  assign col_vld = (diag >= ADDR_WIDTH'(LANE)) && (diff < (ADDR_WIDTH + 1)'(ARRAY_SIZE));
  assign col     = diff[COL_W-1:0];

endmodule

// File: rtl/tpu_result_deskew.sv
// Collects the skewed diagonal stream into an NxN tile, then drains it row by row.
// First beat 1 cycle after the completing write; rows hold while out_ready is low, writes in DRAIN are dropped.
module tpu_result_deskew #(
  parameter  int ARRAY_SIZE = tpu_pkg::ARRAY_SIZE,
  parameter  int W          = tpu_pkg::W,
  parameter  int ADDR_WIDTH = tpu_pkg::ADDR_WIDTH,
  localparam int RW         = $clog2(ARRAY_SIZE)
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    wr_en_n,
  input  logic [ADDR_WIDTH-1:0]   waddr,
  input  logic [ARRAY_SIZE*W-1:0] wdata,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [ARRAY_SIZE*W-1:0] out_data,
  output logic [RW-1:0]           out_row,
  output logic                    out_last,
  output logic                    busy,
  output logic                    overrun,
  output logic                    addr_err
);

  import tpu_pkg::*;

  localparam int NDIAG = 2 * ARRAY_SIZE - 1;
  localparam logic [RW-1:0] LAST_ROW = RW'(ARRAY_SIZE - 1);

  deskew_state_t state_q, state_d;

  logic [W-1:0]       tile_q [ARRAY_SIZE][ARRAY_SIZE];
  logic [NDIAG-1:0]   mask_q;
  logic [NDIAG-1:0]   diag_bit;
  logic [NDIAG-1:0]   mask_nxt;
  logic [RW-1:0]      row_q;
  logic [RW-1:0]      lane_col [ARRAY_SIZE];
  logic [ARRAY_SIZE-1:0] lane_vld;

  logic wr_seen;
  logic addr_ok;
  logic wr_fire;
  logic accept;
  logic tile_done;

  assign wr_seen = !wr_en_n;
  assign addr_ok = (waddr <= ADDR_WIDTH'(NDIAG - 1));
  assign wr_fire = wr_seen && addr_ok && (state_q == COLLECT);
  assign accept  = (state_q == DRAIN) && out_ready;

  for (genvar r = 0; r < ARRAY_SIZE; r++) begin : g_lane
    deskew_lane_mux #(
      .LANE       (r),
      .ADDR_WIDTH (ADDR_WIDTH),
      .ARRAY_SIZE (ARRAY_SIZE),
      .COL_W      (RW)
    ) u_lane_mux (
      .diag    (waddr),
      .col     (lane_col[r]),
      .col_vld (lane_vld[r])
    );
  end

  always_comb begin
    diag_bit = '0;
    for (int i = 0; i < NDIAG; i++) begin
      if (waddr == ADDR_WIDTH'(i)) diag_bit[i] = 1'b1;
    end
  end

  // Mask is zero throughout DRAIN, so tile_done can only fire from COLLECT.
  assign mask_nxt  = mask_q | (wr_fire ? diag_bit : '0);
  assign tile_done = &mask_nxt;

  always_comb begin
    state_d = state_q;
    case (state_q)
      COLLECT: if (tile_done) state_d = DRAIN;
      DRAIN:   if (accept && (row_q == LAST_ROW)) state_d = COLLECT;
      default: state_d = COLLECT;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= COLLECT;
      mask_q   <= '0;
      row_q    <= '0;
      overrun  <= 1'b0;
      addr_err <= 1'b0;
      for (int r = 0; r < ARRAY_SIZE; r++) begin
        for (int c = 0; c < ARRAY_SIZE; c++) begin
          tile_q[r][c] <= '0;
        end
      end
    end else begin
      state_q <= state_d;
      if (state_q == COLLECT) mask_q <= tile_done ? '0 : mask_nxt;
      if (accept) row_q <= (row_q == LAST_ROW) ? '0 : row_q + RW'(1);
      if (wr_seen && (state_q == DRAIN)) overrun <= 1'b1;
      if (wr_seen && !addr_ok) addr_err <= 1'b1;
      if (wr_fire) begin
        for (int r = 0; r < ARRAY_SIZE; r++) begin
          if (lane_vld[r]) tile_q[r][lane_col[r]] <= wdata[(ARRAY_SIZE-r)*W-1 -: W];
        end
      end
    end
  end

  always_comb begin
    out_data = '0;
    for (int c = 0; c < ARRAY_SIZE; c++) begin
      out_data[(ARRAY_SIZE-c)*W-1 -: W] = tile_q[row_q][c];
    end
  end

  assign out_valid = (state_q == DRAIN);
  assign busy      = (state_q == DRAIN);
  assign out_row   = row_q;
  assign out_last  = (state_q == DRAIN) && (row_q == LAST_ROW);

endmodule

// File: tb/tb_tpu_result_deskew.sv
// Directed bench for tpu_result_deskew: ordered/reverse bursts, backpressure, overrun,
// illegal address with duplicate diagonal, and reset mid-drain.
module tb_tpu_result_deskew;

  localparam int N  = 8;
  localparam int WW = 16;
  localparam int AW = 6;

  logic            clock = 1'b0;
  logic            reset;
  logic            wr_en_n;
  logic [AW-1:0]   waddr;
  logic [N*WW-1:0] wdata;
  logic            out_valid;
  logic            out_ready;
  logic [N*WW-1:0] out_data;
  logic [2:0]      out_row;
  logic            out_last;
  logic            busy;
  logic            overrun;
  logic            addr_err;

  int errors = 0;
  int checks = 0;

  tpu_result_deskew #(.ARRAY_SIZE(N), .W(WW), .ADDR_WIDTH(AW)) dut (
    .clock     (clock),
    .reset     (reset),
    .wr_en_n   (wr_en_n),
    .waddr     (waddr),
    .wdata     (wdata),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .out_row   (out_row),
    .out_last  (out_last),
    .busy      (busy),
    .overrun   (overrun),
    .addr_err  (addr_err)
  );

  always #5 clock = ~clock;

  // C[r][c] = base + r*16 + c
  function automatic logic [N*WW-1:0] exp_row(input logic [15:0] base, input int r);
    logic [N*WW-1:0] v;
    v = '0;
    for (int c = 0; c < N; c++) v[(N-c)*WW-1 -: WW] = base + 16'(r * 16 + c);
    return v;
  endfunction

  // Lanes outside the tile carry junk that must be ignored.
  function automatic logic [N*WW-1:0] diag_word(input logic [15:0] base, input int d);
    logic [N*WW-1:0] v;
    int c;
    v = '0;
    for (int r = 0; r < N; r++) begin
      c = d - r;
      if (c >= 0 && c < N) v[(N-r)*WW-1 -: WW] = base + 16'(r * 16 + c);
      else                 v[(N-r)*WW-1 -: WW] = 16'hDEAD;
    end
    return v;
  endfunction

  task automatic write_diag(input int d, input logic [N*WW-1:0] data);
    wr_en_n = 1'b0;
    waddr   = AW'(d);
    wdata   = data;
    @(posedge clock); #1;
    wr_en_n = 1'b1;
  endtask

  task automatic write_range(input logic [15:0] base, input int from, input int to);
    if (from <= to) for (int d = from; d <= to; d++) write_diag(d, diag_word(base, d));
    else            for (int d = from; d >= to; d--) write_diag(d, diag_word(base, d));
  endtask

  task automatic test_reset;
    reset = 1'b1; wr_en_n = 1'b1; waddr = '0; wdata = '0; out_ready = 1'b0;
    repeat (3) @(posedge clock);
    #1;
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %b exp 0", out_valid); end
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy got %b exp 0", busy); end
    checks++; if (out_last !== 1'b0) begin errors++; $display("FAIL reset_last got %b exp 0", out_last); end
    checks++; if (out_row !== 3'd0) begin errors++; $display("FAIL reset_row got %0d exp 0", out_row); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL reset_data got %h exp 0", out_data); end
    checks++; if ({overrun, addr_err} !== 2'b00) begin errors++; $display("FAIL reset_flags got %b exp 00", {overrun, addr_err}); end
    reset = 1'b0;
    @(posedge clock); #1;
  endtask

  task automatic test_ordered_burst;
    out_ready = 1'b1;
    write_range(16'h0000, 0, 13);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ord_early_valid got %b exp 0", out_valid); end
    write_range(16'h0000, 14, 14);
    for (int k = 0; k < N; k++) begin
      checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ord_valid row %0d got %b exp 1", k, out_valid); end
      checks++; if (out_row !== 3'(k)) begin errors++; $display("FAIL ord_row got %0d exp %0d", out_row, k); end
      checks++; if (out_data !== exp_row(16'h0000, k)) begin errors++; $display("FAIL ord_data row %0d got %h exp %h", k, out_data, exp_row(16'h0000, k)); end
      checks++; if (out_last !== (k == N - 1)) begin errors++; $display("FAIL ord_last row %0d got %b exp %b", k, out_last, (k == N - 1)); end
      @(posedge clock); #1;
    end
    checks++; if ({out_valid, busy} !== 2'b00) begin errors++; $display("FAIL ord_after got %b exp 00", {out_valid, busy}); end
  endtask

  // Starts in the cycle right after the previous tile's final accept.
  task automatic test_reverse_order;
    out_ready = 1'b1;
    for (int d = N * 2 - 2; d >= 1; d--) begin
      write_diag(d, diag_word(16'h0000, d));
      checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rev_early_valid d %0d got %b exp 0", d, out_valid); end
    end
    write_diag(0, diag_word(16'h0000, 0));
    for (int k = 0; k < N; k++) begin
      checks++; if (out_row !== 3'(k)) begin errors++; $display("FAIL rev_row got %0d exp %0d", out_row, k); end
      checks++; if (out_data !== exp_row(16'h0000, k)) begin errors++; $display("FAIL rev_data row %0d got %h exp %h", k, out_data, exp_row(16'h0000, k)); end
      checks++; if (out_last !== (k == N - 1)) begin errors++; $display("FAIL rev_last row %0d got %b", k, out_last); end
      @(posedge clock); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rev_after got %b exp 0", out_valid); end
  endtask

  task automatic test_backpressure;
    out_ready = 1'b1;
    write_range(16'h1000, 0, 14);
    for (int k = 0; k < 2; k++) begin
      checks++; if (out_row !== 3'(k)) begin errors++; $display("FAIL bp_row got %0d exp %0d", out_row, k); end
      @(posedge clock); #1;
    end
    out_ready = 1'b0;
    repeat (5) begin
      checks++; if ({out_valid, out_row} !== {1'b1, 3'd2}) begin errors++; $display("FAIL bp_hold_row got %b/%0d exp 1/2", out_valid, out_row); end
      checks++; if (out_data !== exp_row(16'h1000, 2)) begin errors++; $display("FAIL bp_hold_data got %h exp %h", out_data, exp_row(16'h1000, 2)); end
      @(posedge clock); #1;
    end
    out_ready = 1'b1;
    for (int k = 2; k < N; k++) begin
      checks++; if (out_row !== 3'(k)) begin errors++; $display("FAIL bp_resume_row got %0d exp %0d", out_row, k); end
      checks++; if (out_data !== exp_row(16'h1000, k)) begin errors++; $display("FAIL bp_resume_data row %0d got %h", k, out_data); end
      @(posedge clock); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL bp_after got %b exp 0", out_valid); end
  endtask

  task automatic test_overrun;
    out_ready = 1'b1;
    write_range(16'h2000, 0, 14);
    for (int k = 0; k < 5; k++) begin
      checks++; if (out_data !== exp_row(16'h2000, k)) begin errors++; $display("FAIL ovr_data row %0d got %h", k, out_data); end
      @(posedge clock); #1;
    end
    checks++; if (overrun !== 1'b0) begin errors++; $display("FAIL ovr_pre got %b exp 0", overrun); end
    out_ready = 1'b0;
    write_diag(4, {N{16'hFFFF}});
    write_diag(12, {N{16'hFFFF}});
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_flag got %b exp 1", overrun); end
    out_ready = 1'b1;
    for (int k = 5; k < N; k++) begin
      checks++; if (out_row !== 3'(k)) begin errors++; $display("FAIL ovr_row got %0d exp %0d", out_row, k); end
      checks++; if (out_data !== exp_row(16'h2000, k)) begin errors++; $display("FAIL ovr_keep row %0d got %h exp %h", k, out_data, exp_row(16'h2000, k)); end
      @(posedge clock); #1;
    end
    write_range(16'h3000, 0, 13);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ovr_next_early got %b exp 0", out_valid); end
    write_range(16'h3000, 14, 14);
    for (int k = 0; k < N; k++) begin
      checks++; if (out_data !== exp_row(16'h3000, k)) begin errors++; $display("FAIL ovr_next_data row %0d got %h", k, out_data); end
      @(posedge clock); #1;
    end
    checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL ovr_sticky got %b exp 1", overrun); end
  endtask

  task automatic test_addr_err_dup;
    out_ready = 1'b1;
    checks++; if (addr_err !== 1'b0) begin errors++; $display("FAIL ae_pre got %b exp 0", addr_err); end
    write_diag(15, {N{16'hFFFF}});
    checks++; if (addr_err !== 1'b1) begin errors++; $display("FAIL ae_flag got %b exp 1", addr_err); end
    write_diag(7, diag_word(16'h5000, 7));
    write_diag(7, diag_word(16'h4000, 7));
    write_range(16'h4000, 0, 6);
    write_range(16'h4000, 8, 13);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL ae_early got %b exp 0", out_valid); end
    write_range(16'h4000, 14, 14);
    checks++; if (out_valid !== 1'b1) begin errors++; $display("FAIL ae_drain got %b exp 1", out_valid); end
    for (int k = 0; k < N; k++) begin
      checks++; if (out_data !== exp_row(16'h4000, k)) begin errors++; $display("FAIL ae_data row %0d got %h exp %h", k, out_data, exp_row(16'h4000, k)); end
      @(posedge clock); #1;
    end
  endtask

  task automatic test_reset_mid_drain;
    out_ready = 1'b1;
    write_range(16'h6000, 0, 14);
    repeat (4) begin @(posedge clock); #1; end
    checks++; if (out_row !== 3'd4) begin errors++; $display("FAIL rst_at_row got %0d exp 4", out_row); end
    reset = 1'b1;
    @(posedge clock); #1;
    reset = 1'b0;
    checks++; if ({out_valid, busy, out_last} !== 3'b000) begin errors++; $display("FAIL rst_ctl got %b exp 000", {out_valid, busy, out_last}); end
    checks++; if (out_row !== 3'd0) begin errors++; $display("FAIL rst_row got %0d exp 0", out_row); end
    checks++; if (out_data !== '0) begin errors++; $display("FAIL rst_data got %h exp 0", out_data); end
    checks++; if ({overrun, addr_err} !== 2'b00) begin errors++; $display("FAIL rst_flags got %b exp 00", {overrun, addr_err}); end
    write_range(16'h7000, 0, 13);
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_partial got %b exp 0", out_valid); end
    write_range(16'h7000, 14, 14);
    for (int k = 0; k < N; k++) begin
      checks++; if (out_row !== 3'(k)) begin errors++; $display("FAIL rst_new_row got %0d exp %0d", out_row, k); end
      checks++; if (out_data !== exp_row(16'h7000, k)) begin errors++; $display("FAIL rst_new_data row %0d got %h", k, out_data); end
      @(posedge clock); #1;
    end
    checks++; if (out_valid !== 1'b0) begin errors++; $display("FAIL rst_new_after got %b exp 0", out_valid); end
  endtask

  initial begin
    test_reset;
    test_ordered_burst;
    test_reverse_order;
    test_backpressure;
    test_overrun;
    test_addr_err_dup;
    test_reset_mid_drain;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tpu_result_deskew.md
# tpu_result_deskew

Downstream collector for the systolic-array result port. It captures the skewed diagonal write stream the array emits (one 8-lane word per anti-diagonal, active-low write enable), reassembles the 8x8 result tile into row-major order, and streams it out one row per beat over a valid/ready handshake. It replaces ad-hoc result memories and hard-wired unskew wiring between the array and the host-side output interface.

## Interface
- `ARRAY_SIZE`, 8: tile dimension N (rows = columns = lanes).
- `W`, 16: result element width, bits.
- `ADDR_WIDTH`, 6: width of the array's write address.
- `clock`  in  1: clock.
- `reset`  in  1: reset, synchronous, active-high.
- `wr_en_n`  in  1: array write strobe, active low.
- `waddr`  in  ADDR_WIDTH: diagonal index d, valid range 0..2N-2.
- `wdata`  in  N*W: lane r at bits [(N-r)*W-1 -: W]; lane 0 is the MSBs.
- `out_valid`  out  1: row beat available.
- `out_ready`  in  1: consumer accepts the beat.
- `out_data`  out  N*W: row r; column c at bits [(N-c)*W-1 -: W].
- `out_row`  out  3 (clog2 N): index of the row on `out_data`.
- `out_last`  out  1: high with row N-1.
- `busy`  out  1: high in DRAIN.
- `overrun`  out  1: sticky; a write arrived while in DRAIN.
- `addr_err`  out  1: sticky; a write had `waddr` > 2N-2.

## Operation
- Element mapping: C[r][c] is carried in word d = r+c, lane r. Lane r of word d is meaningful only when 0 <= d-r <= N-1; all other lanes are ignored.
- Storage: N*N x W register buffer plus a (2N-1)-bit received mask.
- States: COLLECT (reset state), DRAIN.
- COLLECT: on each edge with `wr_en_n`=0 and a legal `waddr`, write every meaningful lane of `wdata` into C[r][d-r] and set mask bit d. A duplicate d overwrites and is not double-counted. Writes are accepted in any order.
- COLLECT -> DRAIN: occurs on the edge where (mask | new bit) becomes all ones. The mask clears on entry to DRAIN. The row counter is 0.
- DRAIN: `out_valid`=1 and `out_data` = row `out_row`. When `out_valid` & `out_ready` are both high at an edge, the row counter increments. Accepting row N-1 returns the block to COLLECT with the counter reset to 0.
- A write seen in DRAIN, including in the cycle the last beat is accepted, is dropped and sets `overrun`. The buffer is not modified.
- An illegal `waddr` is dropped in any state, sets `addr_err`, and leaves the mask unchanged.
- Sticky flags clear only on reset.
- Reset values: state COLLECT, mask 0, row 0, `out_valid` 0, `out_last` 0, `busy` 0, `overrun` 0, `addr_err` 0. `out_data` is 0 because the buffer resets to 0.
- Reset mid-tile or mid-drain discards all partial data. No beat is emitted afterwards until a full new tile has been collected.

## Timing
- Writes are sampled at the rising edge. There is no combinational path from `wr_en_n`/`wdata` to any output.
- Latency: `out_valid` rises in the cycle after the edge that completes the mask. A back-to-back 15-word burst gives the first beat 1 cycle after the last write.
- `out_data`, `out_row`, and `out_last` are stable while `out_valid`=1 and `out_ready`=0.
- With `out_ready` held high, drain takes exactly N cycles. The block is back in COLLECT in the cycle after the row N-1 accept edge, and can take a write in that cycle.
- Throughput: one tile per (2N-1)+N cycles minimum. There is no overlap; this is a single buffer.

## Structure
- Shared package `tpu_pkg`:
  - `ARRAY_SIZE`, `W`
  - `NUM_DIAG` = 2*ARRAY_SIZE-1
  - `ROW_IDX_W` = clog2(ARRAY_SIZE)
  - state enum `deskew_state_t` {COLLECT, DRAIN}
- One sub-module is natural: `deskew_lane_mux`, a combinational decode of (d, r) to a column index plus a valid bit. It is instantiated per lane.
- Everything else lives in `tpu_result_deskew`.

## Test plan
- Ordered burst: write d=0..14 on consecutive cycles with C[r][c] = 16'h(r*16+c), `out_ready`=1. Required: 8 beats in 8 consecutive cycles starting 1 cycle after d=14; row 3 = 16'h30..16'h37; `out_last` only on row 7.
- Reverse order: write d=14 down to 0. Required: identical output. `out_valid` stays low until d=0 is written.
- Backpressure: hold `out_ready`=0 for 5 cycles at row 2. Required: row 2 data and `out_row`=2 stay stable throughout; no row is skipped.
- Overrun: write d=4 during DRAIN at row 5. Required: `overrun`=1; drained rows unchanged; the next tile collects normally.
- Illegal address and duplicate: write `waddr`=15, then d=7 twice with different data, then the rest. Required: `addr_err`=1; DRAIN entered after the 15 legal diagonals; the second d=7 value appears.
- Reset mid-drain at row 4. Required: all outputs at their reset values next cycle. A fresh 15-write tile then drains starting from row 0.
